// File: rtl/ctrl_pipe.sv
// Decode-to-writeback control pipeline for the five-stage RV32I core: E/M/W control
// registers with stall/flush handling, next-PC select in Execute, and a retired-instruction counter.
module ctrl_pipe #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 validD,
  input  logic                 RegWriteD,
  input  logic                 MemWriteD,
  input  logic                 BranchD,
  input  logic                 JumpD,
  input  logic                 ALUSrcD,
  input  logic                 SrcAsrcD,
  input  logic                 jumpRegD,
  input  logic [1:0]           ResultSrcD,
  input  logic                 StallE,
  input  logic                 FlushE,
  input  logic                 BranchTakenE,
  output logic                 RegWriteE,
  output logic                 MemWriteE,
  output logic                 ALUSrcE,
  output logic                 SrcAsrcE,
  output logic [1:0]           ResultSrcE,
  output logic                 LoadE,
  output logic                 PCSrcE,
  output logic                 TargetSelE,
  output logic                 RegWriteM,
  output logic                 MemWriteM,
  output logic [1:0]           ResultSrcM,
  output logic                 RegWriteW,
  output logic [1:0]           ResultSrcW,
  output logic [CNT_WIDTH-1:0] instret
);

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic       srca_src;
    logic       jump_reg;
    logic [1:0] result_src;
  } e_ctl_t;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
  } m_ctl_t;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic [1:0] result_src;
  } w_ctl_t;

  e_ctl_t               d_bundle;
  e_ctl_t               e_d, e_q;
  m_ctl_t               m_d, m_q;
  w_ctl_t               w_d, w_q;
  logic [CNT_WIDTH-1:0] instret_d, instret_q;

  // An invalid decode slot is turned into a clean bubble so no stray control bit leaks into E.
  always_comb begin
    d_bundle = '0;
    if (validD) begin
      d_bundle.valid      = 1'b1;
      d_bundle.reg_write  = RegWriteD;
      d_bundle.mem_write  = MemWriteD;
      d_bundle.branch     = BranchD;
      d_bundle.jump       = JumpD;
      d_bundle.alu_src    = ALUSrcD;
      d_bundle.srca_src   = SrcAsrcD;
      d_bundle.jump_reg   = jumpRegD;
      d_bundle.result_src = ResultSrcD;
    end
  end

  always_comb begin
    e_d = e_q;
    if (FlushE) begin
      e_d = '0;
    end else if (!StallE) begin
      e_d = d_bundle;
    end
  end

  // A stalled E never advances, so M takes a bubble for every stall cycle, flushed or not.
  always_comb begin
    m_d = '0;
    if (!StallE) begin
      m_d.valid      = e_q.valid;
      m_d.reg_write  = e_q.reg_write;
      m_d.mem_write  = e_q.mem_write;
      m_d.result_src = e_q.result_src;
    end
  end

  always_comb begin
    w_d            = '0;
    w_d.valid      = m_q.valid;
    w_d.reg_write  = m_q.reg_write;
    w_d.result_src = m_q.result_src;
  end

  always_comb begin
    instret_d = instret_q + CNT_WIDTH'(w_q.valid);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q       <= '0;
      m_q       <= '0;
      w_q       <= '0;
      instret_q <= '0;
    end else begin
      e_q       <= e_d;
      m_q       <= m_d;
      w_q       <= w_d;
      instret_q <= instret_d;
    end
  end

  assign RegWriteE  = e_q.valid & e_q.reg_write;
  assign MemWriteE  = e_q.valid & e_q.mem_write;
  assign ALUSrcE    = e_q.alu_src;
  assign SrcAsrcE   = e_q.srca_src;
  assign ResultSrcE = e_q.result_src;
  assign LoadE      = e_q.valid & (e_q.result_src == 2'b01);

  // Masking with StallE keeps a stalled branch/jump from redirecting fetch on every stall cycle.
  assign PCSrcE     = e_q.valid & ~StallE & ((e_q.branch & BranchTakenE) | e_q.jump);
  assign TargetSelE = e_q.jump & ~e_q.jump_reg;

  assign RegWriteM  = m_q.valid & m_q.reg_write;
  assign MemWriteM  = m_q.valid & m_q.mem_write;
  assign ResultSrcM = m_q.result_src;

  assign RegWriteW  = w_q.valid & w_q.reg_write;
  assign ResultSrcW = w_q.result_src;

  assign instret    = instret_q;

endmodule
